// File: rtl/namuru_status_irq.sv
// Status/interrupt block: TIC and accumulation flags, overrun counter and stamp capture.
// Optional feature: define NAMURU_TIC_IRQ_EN to also raise accum_irq on tic_flag.
module namuru_status_irq #(
  parameter int OVF_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tic_enable,
  input  logic                 accum_enable,
  input  logic [23:0]          tic_count,
  input  logic                 status_read,
  input  logic                 ovf_clr,
  output logic                 accum_irq,
  output logic [1:0]           status,
  output logic [23:0]          accum_stamp,
  output logic [OVF_WIDTH-1:0] ovf_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [OVF_WIDTH-1:0] OVF_ZERO = {OVF_WIDTH{1'b0}};
  localparam logic [OVF_WIDTH-1:0] OVF_ONE  = OVF_WIDTH'(1);
  localparam logic [OVF_WIDTH-1:0] OVF_MAX  = {OVF_WIDTH{1'b1}};

  state_t                 state_r, state_s;
  logic                   capture_s;
  logic                   ovf_inc_s;
  logic                   tic_flag_r, tic_flag_s;
  logic                   irq_r, irq_s;
  logic [23:0]            stamp_r;
  logic [OVF_WIDTH-1:0]   ovf_r, ovf_s;

  // Accumulation FSM: a read together with a new event consumes the old one without an overrun
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    ovf_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accum_enable) begin
          state_s   = PEND;
          capture_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      PEND: begin
        if (accum_enable) begin
          state_s   = PEND;
          capture_s = 1'b1;
          ovf_inc_s = ~status_read;
        end else if (status_read) begin
          state_s   = IDLE;
        end else begin
          state_s   = PEND;
        end
      end
      default: begin
        state_s   = IDLE;
      end
    endcase
  end

  // Saturating overrun counter and TIC flag next-state; set beats clear
  always_comb begin
    ovf_s      = ovf_r;
    tic_flag_s = tic_flag_r;
    if (ovf_clr) begin
      ovf_s = ovf_inc_s ? OVF_ONE : OVF_ZERO;
    end else if (ovf_inc_s && (ovf_r != OVF_MAX)) begin
      ovf_s = ovf_r + OVF_ONE;
    end else begin
      ovf_s = ovf_r;
    end
    if (tic_enable) begin
      tic_flag_s = 1'b1;
    end else if (status_read) begin
      tic_flag_s = 1'b0;
    end else begin
      tic_flag_s = tic_flag_r;
    end
  end

  // The irq register tracks the flags' next values so it rises and falls with them
  always_comb begin
`ifdef NAMURU_TIC_IRQ_EN
    irq_s = (state_s == PEND) | tic_flag_s;
`else
    irq_s = (state_s == PEND);
`endif
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      tic_flag_r <= 1'b0;
      irq_r      <= 1'b0;
      stamp_r    <= 24'h000000;
      ovf_r      <= OVF_ZERO;
    end else begin
      state_r    <= state_s;
      tic_flag_r <= tic_flag_s;
      irq_r      <= irq_s;
      stamp_r    <= capture_s ? tic_count : stamp_r;
      ovf_r      <= ovf_s;
    end
  end

  assign status      = {tic_flag_r, (state_r == PEND)};
  assign accum_irq   = irq_r;
  assign accum_stamp = stamp_r;
  assign ovf_count   = ovf_r;

endmodule

// File: doc/namuru_status_irq.md
NAMURU_STATUS_IRQ -- requirements
Module: namuru_status_irq

Interface
REQ-001 The block SHALL have parameter OVF_WIDTH, default 8, the width of the saturating overrun counter.
REQ-002 The block SHALL have port clk, input, 1, the single system clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port tic_enable, input, 1, a one-cycle TIC strobe from the time base.
REQ-005 The block SHALL have port accum_enable, input, 1, a one-cycle accumulation-interrupt strobe from the time base.
REQ-006 The block SHALL have port tic_count, input, 24, the live TIC down-counter value.
REQ-007 The block SHALL have port status_read, input, 1, a one-cycle CPU read strobe of the status register.
REQ-008 The block SHALL have port ovf_clr, input, 1, a one-cycle CPU strobe that clears ovf_count.
REQ-009 The block SHALL have port accum_irq, output, 1, the level interrupt to the CPU.
REQ-010 The block SHALL have port status, output, 2, as {tic_flag, accum_flag}.
REQ-011 The block SHALL have port accum_stamp, output, 24, the tic_count value captured at the last accepted accum_enable.
REQ-012 The block SHALL have port ovf_count, output, OVF_WIDTH, the number of missed accumulation interrupts.

Function
REQ-013 The accumulation path SHALL be a two-state FSM: IDLE, with accum_flag=0, and PEND, with accum_flag=1.
REQ-014 In IDLE, accum_enable=1 SHALL move the FSM to PEND and capture tic_count into accum_stamp on the same edge.
- Consequence: accum_flag is high in the cycle after the strobe.
REQ-015 In PEND, status_read=1 with accum_enable=0 SHALL return the FSM to IDLE.
- accum_stamp is held.
REQ-016 In PEND, accum_enable=1 with status_read=0 SHALL leave the FSM in PEND, increment ovf_count, and recapture accum_stamp.
REQ-017 In PEND, accum_enable=1 and status_read=1 in the same cycle SHALL leave the FSM in PEND and recapture accum_stamp, with no overrun counted.
- Reasoning: the old event is consumed and the new event becomes pending.
REQ-018 ovf_count SHALL saturate at 2^OVF_WIDTH-1 and never wrap.
REQ-019 ovf_clr=1 SHALL zero ovf_count on the next edge.
REQ-020 If ovf_clr=1 and an overrun occur in the same cycle, ovf_count SHALL become 1.
REQ-021 tic_flag SHALL set on tic_enable=1 and clear on status_read=1.
- If both occur in the same cycle, set SHALL win.
REQ-022 status SHALL be driven directly from the flag registers, with no combinational path from inputs to status.
REQ-023 accum_irq SHALL be registered and high whenever accum_flag=1, plus any contribution defined under Configuration.
- Latency: strobe to irq is exactly 1 cycle.
- Latency: status_read to irq deassertion is exactly 1 cycle.
REQ-024 tic_enable and accum_enable asserted in the same cycle SHALL both be recorded independently.
REQ-025 Strobes held high for more than one cycle SHALL be treated as one event per cycle, with no edge detection.

Reset
REQ-026 rstn=0 SHALL immediately and asynchronously force the following:
- FSM to IDLE;
- tic_flag=0, status=2'b00;
- accum_irq=0;
- accum_stamp=24'h000000;
- ovf_count=0.
REQ-027 Reset asserted while in PEND SHALL discard the pending event, and no overrun SHALL be recorded.
REQ-028 The block SHALL ignore all inputs while rstn=0, and the first event SHALL be accepted on the first rising edge after rstn returns high.

Configuration
REQ-029 With macro NAMURU_TIC_IRQ_EN defined, accum_irq SHALL equal accum_flag OR tic_flag.
REQ-030 Without NAMURU_TIC_IRQ_EN, accum_irq SHALL equal accum_flag only.
- tic_flag remains readable in status[1] either way.

Verification
REQ-031 Accumulation event and read: release reset, pulse accum_enable with tic_count=24'h18FF00 -> next cycle accum_irq=1, status=2'b01, accum_stamp=24'h18FF00; pulse status_read -> next cycle accum_irq=0, status=2'b00.
REQ-032 Overrun and saturation: three accum_enable pulses with no read -> ovf_count=2, accum_stamp equals the third capture; with OVF_WIDTH=2, pulse 5 more -> ovf_count saturates at 3; ovf_clr -> 0.
REQ-033 Simultaneous read and event: in PEND, status_read and accum_enable in the same cycle -> status[0] stays 1, ovf_count unchanged, accum_stamp updated.
REQ-034 TIC interrupt macro: tic_enable pulse -> status=2'b10; with NAMURU_TIC_IRQ_EN defined accum_irq=1, without it accum_irq=0; status_read -> status=2'b00.
REQ-035 Reset mid-operation: in PEND with ovf_count=4, drop rstn for half a clock -> all outputs zero immediately without waiting for a clock edge; after release, one accum_enable -> ovf_count=0, status=2'b01.
